button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front end for the up/down value FSM: turns raw, bouncy, asynchronous plus/minus pushbutton inputs into clean single-cycle pulses on plus_processed and minus_processed.
- Sits between the board pushbuttons and the 4-bit counter FSM, in the clk_100hz domain.
- Provides synchronisation, debounce, one-pulse, hold-to-auto-repeat and plus/minus mutual exclusion, so the two pulses are never high together.

Parameters:
- DEBOUNCE_LEN, 4: consecutive equal synchronised samples required to change a debounced level (legal range 2..16).
- REPEAT_EN, 1: 1 enables auto-repeat while a button is held; 0 gives one pulse per press.
- REPEAT_DELAY, 50: cycles from the initial pulse to the first repeat pulse (0.5 s at 100 Hz); must be ≥2.
- REPEAT_RATE, 10: cycles between subsequent repeat pulses (0.1 s); must be ≥2.

Ports:
- clk_100hz  input  1  system clock, 100 Hz
- rst  input  1  reset, asynchronous, active-low
- pb_plus_raw  input  1  raw plus button, active-high, asynchronous, bouncy
- pb_minus_raw  input  1  raw minus button, active-high, asynchronous, bouncy
- plus_processed  output  1  one-cycle increment pulse
- minus_processed  output  1  one-cycle decrement pulse
- plus_level  output  1  debounced plus level
- minus_level  output  1  debounced minus level

Behaviour:
- Reset, rst low and asynchronous: all synchroniser flops, shift registers, levels, counters and pulse outputs go to 0; both channel FSMs go to IDLE. A reset mid-hold or mid-repeat aborts with no pulse. After rst goes high, a still-held button is treated as a new press: the full latency applies.
- Synchroniser: 2 flops per input; the output of the second flop feeds the debouncer.
- Debouncer:
  - DEBOUNCE_LEN-bit shift register per channel.
  - Level goes to 1 when all bits are 1, goes to 0 when all bits are 0, and holds otherwise.
  - Glitches shorter than DEBOUNCE_LEN cycles never change the level.
- Latency: raw high first sampled at edge E0 → level high and pulse high from edge E(DEBOUNCE_LEN+2), pulse lasting exactly 1 cycle (E6 for the default). Release has the same latency.
- Per-channel FSM states: IDLE, FIRE, HOLD, REPEAT, LOCKED.
  - IDLE: on a level rise with the other level low → FIRE; if the other level is high → LOCKED.
  - FIRE: pulse = 1 for this cycle only; reload counter with REPEAT_DELAY-1. Then → HOLD if REPEAT_EN, else → LOCKED.
  - HOLD / REPEAT: counter decrements each cycle. At 0: emit a 1-cycle pulse, reload with REPEAT_RATE-1, state = REPEAT.
  - Any state: own level low → IDLE, with no pulse that cycle.
  - HOLD or REPEAT: other level high → LOCKED, with no pulse that cycle.
  - LOCKED: no pulses; exits to IDLE only when own level falls.
- Simultaneous events:
  - Both levels rise in the same cycle → both channels go to LOCKED; neither pulses.
  - Invariant: plus_processed & minus_processed is never 1.
- Counter width: clog2(max(REPEAT_DELAY, REPEAT_RATE)); counters are saturating-free and never wrap, because they are always reloaded.
- Timing of repeats: initial pulse at cycle T; repeats at T+REPEAT_DELAY, then every REPEAT_RATE cycles after that, while held.
- Release: pulses stop in the cycle the level falls. A new press requires a fresh debounced rise.

Test Plan:
1. Defaults. Assert rst low for 3 cycles, then pb_plus_raw=1 from edge E0 → plus_processed high only during cycle E6→E7; plus_level=1 from E6; minus outputs stay 0.
2. Bounce: toggle pb_minus_raw 1,0,1,0,1 on successive cycles, then hold 1 → no pulse during the bounce; exactly one minus_processed, 6 cycles after the start of the stable-high run.
3. Auto-repeat: hold plus for 80 cycles after the initial pulse at T → pulses at T, T+50, T+60, T+70, T+80; release → no further pulses.
4. Mutual exclusion:
   - Raise both raw inputs on the same edge → zero pulses on either output for 100 cycles.
   - Hold plus (pulse at T), then press minus at T+20 → no minus pulse and no plus repeat at T+50; release both, then press minus alone → one minus pulse.
5. REPEAT_EN=0: hold plus for 200 cycles → exactly 1 pulse; release for 10 cycles and press again → 1 more pulse.
6. Reset mid-operation: drop rst while in REPEAT, hold low for 2 cycles, release with plus still held → all outputs 0 during reset; next pulse 6 cycles after rst goes high; the invariant plus&minus==0 is checked on every cycle of every test.

Source files
------------

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Groups the pushbutton-side and FSM-side signals of the button conditioner.
//   Pulse semantics: plus_processed / minus_processed are single-cycle
//   strobes in the clk_100hz domain. There is no back-pressure: the consumer
//   must act on every cycle a strobe is high. The two strobes are never high
//   together.
//   Signals:
//     pb_plus_raw, pb_minus_raw        raw asynchronous buttons (active-high)
//     plus_processed, minus_processed  one-cycle increment / decrement pulses
//     plus_level, minus_level          debounced button levels
//     plus_state, minus_state          channel FSM state, for observation
//   Modports:
//     master  drives the raw buttons and consumes the outputs (board / bench)
//     slave   the conditioner itself
interface button_conditioner_if;
  logic       pb_plus_raw;
  logic       pb_minus_raw;
  logic       plus_processed;
  logic       minus_processed;
  logic       plus_level;
  logic       minus_level;
  logic [2:0] plus_state;
  logic [2:0] minus_state;

  modport master (
    output pb_plus_raw, pb_minus_raw,
    input  plus_processed, minus_processed, plus_level, minus_level,
    input  plus_state, minus_state
  );

  modport slave (
    input  pb_plus_raw, pb_minus_raw,
    output plus_processed, minus_processed, plus_level, minus_level,
    output plus_state, minus_state
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns bouncy asynchronous plus/minus pushbuttons into clean single-cycle
//   pulses for the up/down counter FSM. Per channel: 2-flop synchroniser,
//   DEBOUNCE_LEN-sample debouncer, and a pulse FSM providing one-pulse,
//   hold-to-auto-repeat and plus/minus mutual exclusion.
//   Ports:
//     clk_100hz  system clock (100 Hz)
//     rst        asynchronous active-low reset
//     bus        button_conditioner_if.slave (raw inputs, pulses, levels,
//                FSM state for observation)
//   Latency: a raw rise first sampled at edge E0 raises the level and the
//   pulse at edge E(DEBOUNCE_LEN+2); release has the same latency.
module button_conditioner #(
  parameter int DEBOUNCE_LEN = 4,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                 clk_100hz,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRE   = 3'd1,
    HOLD   = 3'd2,
    REPEAT = 3'd3,
    LOCKED = 3'd4
  } state_t;

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             pulse;
  } chan_t;

  // Synchroniser, debounce shift registers and debounced levels
  logic                    plus_meta_q, plus_sync_q;
  logic                    minus_meta_q, minus_sync_q;
  logic [DEBOUNCE_LEN-1:0] plus_sr_q, minus_sr_q;
  logic                    plus_lv_q, minus_lv_q;
  logic                    plus_lv_n, minus_lv_n;

  // Channel FSMs
  state_t           plus_state_q, minus_state_q;
  logic [CNT_W-1:0] plus_cnt_q, minus_cnt_q;
  chan_t            plus_nx, minus_nx;

  // Next debounced level: set on all-ones, clear on all-zeros, else hold.
  always_comb begin
    plus_lv_n = plus_lv_q;
    if (&plus_sr_q)       plus_lv_n = 1'b1;
    else if (~|plus_sr_q) plus_lv_n = 1'b0;

    minus_lv_n = minus_lv_q;
    if (&minus_sr_q)       minus_lv_n = 1'b1;
    else if (~|minus_sr_q) minus_lv_n = 1'b0;
  end

  // Next-state / output logic for one channel.
  // The IDLE exit looks at the *next* levels so FIRE coincides with the
  // cycle the debounced level first reads high. All other decisions use the
  // current registered levels. The pulse is gated by the current levels, so
  // the cycle the own level drops or the other level rises never pulses, and
  // the two channels can never pulse together.
  function automatic chan_t chan_next(
    input state_t           st,
    input logic [CNT_W-1:0] cnt,
    input logic             own_q,
    input logic             own_n,
    input logic             oth_q,
    input logic             oth_n
  );
    chan_t r;
    r.st    = st;
    r.cnt   = cnt;
    r.pulse = 1'b0;
    case (st)
      IDLE: begin
        if (own_n && !own_q) begin
          r.st = oth_n ? LOCKED : FIRE;
        end
      end
      FIRE: begin
        r.pulse = 1'b1;
        r.cnt   = CNT_W'(REPEAT_DELAY - 1);
        if (!own_q)              r.st = IDLE;
        else if (REPEAT_EN != 0) r.st = HOLD;
        else                     r.st = LOCKED;
      end
      HOLD, REPEAT: begin
        r.pulse = (cnt == '0);
        if (!own_q) begin
          r.st = IDLE;
        end else if (oth_q) begin
          r.st = LOCKED;
        end else if (cnt == '0) begin
          r.st  = REPEAT;
          r.cnt = CNT_W'(REPEAT_RATE - 1);
        end else begin
          r.cnt = cnt - 1'b1;
        end
      end
      LOCKED: begin
        if (!own_q) r.st = IDLE;
      end
      default: r.st = IDLE;
    endcase
    r.pulse = r.pulse & own_q & ~oth_q;
    return r;
  endfunction

  always_comb begin
    plus_nx  = chan_next(plus_state_q, plus_cnt_q, plus_lv_q, plus_lv_n,
                         minus_lv_q, minus_lv_n);
    minus_nx = chan_next(minus_state_q, minus_cnt_q, minus_lv_q, minus_lv_n,
                         plus_lv_q, plus_lv_n);
  end

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      plus_meta_q   <= 1'b0;
      plus_sync_q   <= 1'b0;
      minus_meta_q  <= 1'b0;
      minus_sync_q  <= 1'b0;
      plus_sr_q     <= '0;
      minus_sr_q    <= '0;
      plus_lv_q     <= 1'b0;
      minus_lv_q    <= 1'b0;
      plus_state_q  <= IDLE;
      minus_state_q <= IDLE;
      plus_cnt_q    <= '0;
      minus_cnt_q   <= '0;
    end else begin
      plus_meta_q   <= bus.pb_plus_raw;
      plus_sync_q   <= plus_meta_q;
      minus_meta_q  <= bus.pb_minus_raw;
      minus_sync_q  <= minus_meta_q;
      plus_sr_q     <= {plus_sr_q[DEBOUNCE_LEN-2:0], plus_sync_q};
      minus_sr_q    <= {minus_sr_q[DEBOUNCE_LEN-2:0], minus_sync_q};
      plus_lv_q     <= plus_lv_n;
      minus_lv_q    <= minus_lv_n;
      plus_state_q  <= plus_nx.st;
      minus_state_q <= minus_nx.st;
      plus_cnt_q    <= plus_nx.cnt;
      minus_cnt_q   <= minus_nx.cnt;
    end
  end

  assign bus.plus_processed  = plus_nx.pulse;
  assign bus.minus_processed = minus_nx.pulse;
  assign bus.plus_level      = plus_lv_q;
  assign bus.minus_level     = minus_lv_q;
  assign bus.plus_state      = plus_state_q;
  assign bus.minus_state     = minus_state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner. dut0 uses default parameters,
//   dut1 has auto-repeat disabled. Inputs change just after the falling edge;
//   outputs are sampled on the falling edge. Cycle number k denotes the state
//   after rising edge k. A raw change driven while cyc == c is first sampled
//   at edge c+1 (E0), so the pulse is expected at cycle c+7 (E6).
//   Pulses are logged as cycle*4 + channel (0 dut0 plus, 1 dut0 minus,
//   2 dut1 plus, 3 dut1 minus) and compared against exp_q.
module tb_button_conditioner;

  // Clock / reset
  logic clk_100hz = 1'b0;
  logic rst       = 1'b0;
  always #5 clk_100hz = ~clk_100hz;

  button_conditioner_if bus0 ();
  button_conditioner_if bus1 ();

  button_conditioner #(
    .DEBOUNCE_LEN(4), .REPEAT_EN(1), .REPEAT_DELAY(50), .REPEAT_RATE(10)
  ) dut0 (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .bus       (bus0)
  );

  button_conditioner #(
    .DEBOUNCE_LEN(4), .REPEAT_EN(0), .REPEAT_DELAY(50), .REPEAT_RATE(10)
  ) dut1 (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .bus       (bus1)
  );

  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance n cycles; at each falling edge check exclusion and log pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100hz);
      cyc++;
      @(negedge clk_100hz);
      check("excl0", {31'd0, bus0.plus_processed & bus0.minus_processed}, 32'd0);
      check("excl1", {31'd0, bus1.plus_processed & bus1.minus_processed}, 32'd0);
      if (bus0.plus_processed  === 1'b1) obs_q.push_back(cyc * 4 + 0);
      if (bus0.minus_processed === 1'b1) obs_q.push_back(cyc * 4 + 1);
      if (bus1.plus_processed  === 1'b1) obs_q.push_back(cyc * 4 + 2);
      if (bus1.minus_processed === 1'b1) obs_q.push_back(cyc * 4 + 3);
    end
  endtask

  // Driver
  task automatic drive0(input logic p, input logic m);
    bus0.pb_plus_raw  = p;
    bus0.pb_minus_raw = m;
  endtask

  task automatic drive1(input logic p, input logic m);
    bus1.pb_plus_raw  = p;
    bus1.pb_minus_raw = m;
  endtask

  task automatic expect_pulse(input int c, input int chan);
    exp_q.push_back(c * 4 + chan);
  endtask

  // Scoreboard: compare logged pulses with expectations, then clear both.
  task automatic compare_pulses(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_pulse"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs0(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, bus0.plus_processed, bus0.minus_processed,
                bus0.plus_level, bus0.minus_level}, {28'd0, exp});
  endtask

  int c, t, r;

  initial begin
    drive0(1'b0, 1'b0);
    drive1(1'b0, 1'b0);

    // Reset held low for 3 cycles
    step(3);
    check_outputs0("rst_out0", 4'b0000);
    check("rst_state0", {29'd0, bus0.plus_state}, 32'd0);
    rst = 1'b1;
    obs_q.delete();

    // Test 1 + 3: press plus, latency, then auto-repeat and release
    c = cyc;
    drive0(1'b1, 1'b0);
    step(6);
    check_outputs0("t1_e5", 4'b0000);
    step(1);
    check_outputs0("t1_e6", 4'b1010);
    step(1);
    check_outputs0("t1_e7", 4'b0010);
    t = c + 7;
    expect_pulse(t, 0);
    expect_pulse(t + 50, 0);
    expect_pulse(t + 60, 0);
    expect_pulse(t + 70, 0);
    expect_pulse(t + 80, 0);
    step(t + 80 - cyc);
    drive0(1'b0, 1'b0);
    step(6);
    check("t3_rel_lv_hi", {31'd0, bus0.plus_level}, 32'd1);
    step(1);
    check("t3_rel_lv_lo", {31'd0, bus0.plus_level}, 32'd0);
    step(13);
    compare_pulses("t3");

    // Test 2: bounce on minus, stable run starts with the fifth drive
    drive0(1'b0, 1'b1); step(1);
    drive0(1'b0, 1'b0); step(1);
    drive0(1'b0, 1'b1); step(1);
    drive0(1'b0, 1'b0); step(1);
    c = cyc;
    drive0(1'b0, 1'b1);
    expect_pulse(c + 7, 1);
    step(6);
    check("t2_lv_e5", {31'd0, bus0.minus_level}, 32'd0);
    step(21);
    check("t2_lv_held", {31'd0, bus0.minus_level}, 32'd1);
    drive0(1'b0, 1'b0);
    step(10);
    compare_pulses("t2");

    // Test 4a: both raw inputs rise on the same edge
    drive0(1'b1, 1'b1);
    step(100);
    check_outputs0("t4a_levels", 4'b0011);
    drive0(1'b0, 1'b0);
    step(10);
    compare_pulses("t4a");

    // Test 4b: plus held, minus pressed 20 cycles after the plus pulse
    c = cyc;
    drive0(1'b1, 1'b0);
    t = c + 7;
    expect_pulse(t, 0);
    step(t + 20 - cyc);
    drive0(1'b1, 1'b1);
    step(50);
    check("t4b_state", {29'd0, bus0.plus_state}, 32'd4);
    drive0(1'b0, 1'b0);
    step(10);
    c = cyc;
    drive0(1'b0, 1'b1);
    expect_pulse(c + 7, 1);
    step(17);
    drive0(1'b0, 1'b0);
    step(10);
    compare_pulses("t4b");

    // Test 5: dut1 without auto-repeat
    c = cyc;
    drive1(1'b1, 1'b0);
    expect_pulse(c + 7, 2);
    step(200);
    drive1(1'b0, 1'b0);
    step(10);
    c = cyc;
    drive1(1'b1, 1'b0);
    expect_pulse(c + 7, 2);
    step(20);
    drive1(1'b0, 1'b0);
    step(10);
    compare_pulses("t5");

    // Test 6: reset during REPEAT with plus still held
    c = cyc;
    drive0(1'b1, 1'b0);
    t = c + 7;
    expect_pulse(t, 0);
    expect_pulse(t + 50, 0);
    step(t + 55 - cyc);
    check("t6_state", {29'd0, bus0.plus_state}, 32'd3);
    rst = 1'b0;
    #1;
    check_outputs0("t6_async", 4'b0000);
    step(1);
    check_outputs0("t6_rst1", 4'b0000);
    step(1);
    check_outputs0("t6_rst2", 4'b0000);
    r = cyc;
    rst = 1'b1;
    expect_pulse(r + 7, 0);
    step(6);
    check_outputs0("t6_e5", 4'b0000);
    step(1);
    check_outputs0("t6_e6", 4'b1010);
    step(5);
    drive0(1'b0, 1'b0);
    step(10);
    compare_pulses("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
